// File: rtl/tlb_inv_seq_pkg.sv
// Shared INVTLB op codes, page-size codes and sequencer state encoding.
package tlb_inv_seq_pkg;

    localparam logic [4:0] INV_ALL0    = 5'd0;
    localparam logic [4:0] INV_ALL1    = 5'd1;
    localparam logic [4:0] INV_GLB     = 5'd2;
    localparam logic [4:0] INV_NGLB    = 5'd3;
    localparam logic [4:0] INV_ASID    = 5'd4;
    localparam logic [4:0] INV_ASID_VA = 5'd5;
    localparam logic [4:0] INV_GVA     = 5'd6;

    localparam logic [5:0] TLB_PS_4K = 6'd12;
    localparam logic [5:0] TLB_PS_2M = 6'd21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } inv_state_e;

    function automatic logic op_is_legal(input logic [4:0] op);
        return (op <= INV_GVA);
    endfunction

endpackage

// File: rtl/tlb_inv_match.sv
// Combinational INVTLB match of one TLB entry against the latched request.
module tlb_inv_match
    import tlb_inv_seq_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [9:0]  asid_i,
    input  logic [18:0] va_vpn_i,
    input  logic        g_i,
    input  logic [5:0]  ps_i,
    input  logic [9:0]  e_asid_i,
    input  logic [18:0] e_vppn_i,
    output logic        match_o
);

    logic vmatch_s;
    logic amatch_s;

    assign amatch_s = (e_asid_i == asid_i);

    // Virtual-page compare; a 2M page ignores the low 9 VPPN bits.
    always_comb begin
        vmatch_s = 1'b0;
        case (ps_i)
            TLB_PS_2M: vmatch_s = (e_vppn_i[18:9] == va_vpn_i[18:9]);
            TLB_PS_4K: vmatch_s = (e_vppn_i == va_vpn_i);
            default:   vmatch_s = (e_vppn_i == va_vpn_i);
        endcase
    end

    // Op-specific selection between global, ASID and VA conditions.
    always_comb begin
        match_o = 1'b0;
        case (op_i)
            INV_ALL0, INV_ALL1: match_o = 1'b1;
            INV_GLB:            match_o = g_i;
            INV_NGLB:           match_o = !g_i;
            INV_ASID:           match_o = !g_i && amatch_s;
            INV_ASID_VA:        match_o = !g_i && amatch_s && vmatch_s;
            INV_GVA:            match_o = (g_i || amatch_s) && vmatch_s;
            default:            match_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/tlb_inv_seq.sv
// Multi-cycle INVTLB sequencer: walks every TLB entry and clears matching E bits.
// Optional TLB_INV_STAT_EN adds the inv_cnt cleared-entry counter output.
module tlb_inv_seq
    import tlb_inv_seq_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [9:0]       req_asid,
    input  logic [31:0]      req_va,
    output logic             busy,
    output logic [IDX_W-1:0] r_index,
    input  logic             r_e,
    input  logic             r_g,
    input  logic [5:0]       r_ps,
    input  logic [9:0]       r_asid,
    input  logic [18:0]      r_vppn,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_index,
    output logic             done,
    output logic             err
`ifdef TLB_INV_STAT_EN
    ,
    output logic [IDX_W:0]   inv_cnt
`endif
);

    inv_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [4:0]       op_q;
    logic [9:0]       asid_q;
    logic [18:0]      va_vpn_q;
    logic             err_q;
    logic             match_s;
    logic             unused_va_s;

    // Page offset bits never take part in the compare.
    assign unused_va_s = ^req_va[12:0];

    tlb_inv_match u_match (
        .op_i     (op_q),
        .asid_i   (asid_q),
        .va_vpn_i (va_vpn_q),
        .g_i      (r_g),
        .ps_i     (r_ps),
        .e_asid_i (r_asid),
        .e_vppn_i (r_vppn),
        .match_o  (match_s)
    );

    // Request latch, entry walk and completion handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            op_q     <= 5'd0;
            asid_q   <= 10'd0;
            va_vpn_q <= 19'd0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        asid_q   <= req_asid;
                        va_vpn_q <= req_va[31:13];
                        idx_q    <= '0;
                        err_q    <= !op_is_legal(req_op);
                        state_q  <= op_is_legal(req_op) ? ST_SCAN : ST_DONE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (idx_q == IDX_W'(TLBNUM - 1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    idx_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    idx_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_SCAN);
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_DONE) && err_q;
    assign r_index   = idx_q;
    assign clr_index = idx_q;
    // Gating with reset makes a mid-scan reset abort before its own edge writes.
    assign clr_we    = busy && r_e && match_s && !reset;

`ifdef TLB_INV_STAT_EN
    logic [IDX_W:0] cnt_q;

    // Counts clears of the current invalidate; held until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (req_ready && req_valid) begin
            cnt_q <= '0;
        end else if (clr_we) begin
            cnt_q <= cnt_q + (IDX_W + 1)'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign inv_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_tlb_inv_seq.sv
// Self-checking bench for tlb_inv_seq: directed and randomized INVTLB scans vs a reference model.
module tb_tlb_inv_seq;
    localparam int TLBNUM = 16;
    localparam int IDX_W  = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [4:0]       req_op = 5'd0;
    logic [9:0]       req_asid = 10'd0;
    logic [31:0]      req_va = 32'd0;
    logic             busy;
    logic [IDX_W-1:0] r_index;
    logic             r_e, r_g;
    logic [5:0]       r_ps;
    logic [9:0]       r_asid;
    logic [18:0]      r_vppn;
    logic             clr_we;
    logic [IDX_W-1:0] clr_index;
    logic             done, err;
`ifdef TLB_INV_STAT_EN
    logic [IDX_W:0]   inv_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    // TLB array seen by the DUT, plus the bench's own model of E bits.
    logic        tlb_e  [TLBNUM];
    logic        ld_e   [TLBNUM];
    logic        ld_go = 1'b0;
    logic        ent_g  [TLBNUM];
    logic [5:0]  ent_ps [TLBNUM];
    logic [9:0]  ent_asid [TLBNUM];
    logic [18:0] ent_vppn [TLBNUM];
    bit          m_e    [TLBNUM];

    always #5 clk = ~clk;

    tlb_inv_seq #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_asid(req_asid), .req_va(req_va), .busy(busy),
        .r_index(r_index), .r_e(r_e), .r_g(r_g), .r_ps(r_ps), .r_asid(r_asid),
        .r_vppn(r_vppn), .clr_we(clr_we), .clr_index(clr_index), .done(done), .err(err)
`ifdef TLB_INV_STAT_EN
        , .inv_cnt(inv_cnt)
`endif
    );

    assign r_e    = tlb_e[r_index];
    assign r_g    = ent_g[r_index];
    assign r_ps   = ent_ps[r_index];
    assign r_asid = ent_asid[r_index];
    assign r_vppn = ent_vppn[r_index];

    always @(posedge clk) begin
        if (ld_go) tlb_e <= ld_e;
        else if (clr_we) tlb_e[clr_index] <= 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference rule set written directly from the op definitions.
    function automatic bit spec_match(input int unsigned op, input bit g, input int unsigned ps,
                                      input int unsigned easid, input int unsigned vppn,
                                      input int unsigned qasid, input logic [31:0] va);
        bit am, vm;
        am = (easid == qasid);
        if (ps == 21) vm = ((vppn >> 9) == (va >> 22));
        else          vm = (vppn == (va >> 13));
        case (op)
            0, 1:    return 1'b1;
            2:       return g;
            3:       return !g;
            4:       return !g && am;
            5:       return !g && am && vm;
            6:       return (g || am) && vm;
            default: return 1'b0;
        endcase
    endfunction

    task automatic load_tlb();
        @(negedge clk);
        for (int i = 0; i < TLBNUM; i++) begin
            ld_e[i] = m_e[i];
        end
        ld_go = 1'b1;
        @(negedge clk);
        ld_go = 1'b0;
    endtask

    task automatic set_entry(input int i, input bit e, input bit g, input int unsigned ps,
                             input int unsigned asid, input int unsigned vppn);
        m_e[i] = e; ent_g[i] = g; ent_ps[i] = 6'(ps);
        ent_asid[i] = 10'(asid); ent_vppn[i] = 19'(vppn);
    endtask

    task automatic compare_tlb(input string tag);
        for (int i = 0; i < TLBNUM; i++) check(tag, 32'(tlb_e[i]), 32'(m_e[i]));
    endtask

    // One complete invalidate, checked cycle by cycle; called just after a negedge.
    task automatic run_inv(input logic [4:0] op, input logic [9:0] asid, input logic [31:0] va,
                           input bit keep_valid);
        bit exp_clr [TLBNUM];
        bit legal;
        int n_exp = 0;
        legal = (op <= 5'd6);
        for (int i = 0; i < TLBNUM; i++) begin
            exp_clr[i] = legal && m_e[i] &&
                         spec_match(op, ent_g[i], ent_ps[i], ent_asid[i], ent_vppn[i], asid, va);
            if (exp_clr[i]) n_exp++;
        end
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_asid = asid; req_va = va;
        @(posedge clk);
        if (legal) begin
            for (int k = 0; k < TLBNUM; k++) begin
                @(negedge clk);
                check("busy_scan", 32'(busy), 32'd1);
                check("r_index", 32'(r_index), 32'(k));
                check("clr_we", 32'(clr_we), 32'(exp_clr[k]));
                if (exp_clr[k]) check("clr_index", 32'(clr_index), 32'(k));
            end
        end
        @(negedge clk);
        check("done", 32'(done), 32'd1);
        check("err", 32'(err), 32'(!legal));
        check("busy_done", 32'(busy), 32'd0);
        check("ready_done", 32'(req_ready), 32'd0);
        check("clr_done", 32'(clr_we), 32'd0);
`ifdef TLB_INV_STAT_EN
        check("inv_cnt", 32'(inv_cnt), 32'(n_exp));
`endif
        if (!keep_valid) req_valid = 1'b0;
        for (int i = 0; i < TLBNUM; i++) if (exp_clr[i]) m_e[i] = 1'b0;
        compare_tlb("e_after");
    endtask

    initial begin
        logic [31:0] va;
        int unsigned rop;
        for (int i = 0; i < TLBNUM; i++) set_entry(i, 1'b0, 1'b0, 12, 0, 0);
        ld_go = 1'b1;
        for (int i = 0; i < TLBNUM; i++) ld_e[i] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ld_go = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rindex", 32'(r_index), 32'd0);
        check("rst_clr", 32'(clr_we), 32'd0);
`ifdef TLB_INV_STAT_EN
        check("rst_cnt", 32'(inv_cnt), 32'd0);
`endif

        // Test 1: invalidate everything.
        for (int i = 0; i < TLBNUM; i++) set_entry(i, 1'b1, 1'($urandom), 12, $urandom, $urandom);
        load_tlb();
        run_inv(5'd0, 10'h0, 32'h0, 1'b0);

        // Test 2: global vs non-global.
        for (int i = 0; i < TLBNUM; i++) set_entry(i, 1'b1, (i == 3 || i == 7), 12, i, i);
        load_tlb();
        run_inv(5'd2, 10'h0, 32'h0, 1'b0);
        @(negedge clk);
        run_inv(5'd3, 10'h0, 32'h0, 1'b0);

        // Test 3: ASID+VA with 4K and 2M pages.
        va = 32'h1234_5678;
        for (int i = 0; i < TLBNUM; i++) set_entry(i, 1'b1, 1'b0, 12, 10'h20, va >> 13);
        set_entry(5, 1'b1, 1'b0, 12, 10'h12, va >> 13);
        set_entry(9, 1'b1, 1'b0, 21, 10'h12, ((va >> 22) << 9) | ((~(va >> 13)) & 32'h1FF));
        set_entry(11, 1'b1, 1'b0, 12, 10'h13, va >> 13);
        load_tlb();
        run_inv(5'd5, 10'h12, va, 1'b0);
        check("t3_e5", 32'(m_e[5]), 32'd0);
        check("t3_e9", 32'(m_e[9]), 32'd0);
        check("t3_e11", 32'(tlb_e[11]), 32'd1);

        // Test 4: illegal op never scans.
        @(negedge clk);
        run_inv(5'd7, 10'h0, 32'h0, 1'b0);
        @(negedge clk);
        run_inv(5'd31, 10'h3, 32'hFFFF_FFFF, 1'b0);

        // Test 5: reset during the scan at index 6.
        for (int i = 0; i < TLBNUM; i++) set_entry(i, 1'b1, 1'b0, 12, 0, 0);
        load_tlb();
        req_valid = 1'b1; req_op = 5'd0;
        @(posedge clk);
        for (int k = 0; k < 7; k++) @(negedge clk);
        check("t5_idx6", 32'(r_index), 32'd6);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_ready", 32'(req_ready), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("t5_noclr", 32'(clr_we), 32'd0);
            @(negedge clk);
        end
        for (int i = 0; i < TLBNUM; i++) begin
            if (i < 6) check("t5_cleared", 32'(tlb_e[i]), 32'd0);
            else if (i > 6) check("t5_intact", 32'(tlb_e[i]), 32'd1);
        end
        for (int i = 0; i < TLBNUM; i++) m_e[i] = tlb_e[i];

        // Test 6: req_valid held through done must wait for IDLE.
        for (int i = 0; i < TLBNUM; i++) set_entry(i, 1'b1, 1'b0, 12, 0, 0);
        load_tlb();
        run_inv(5'd0, 10'h0, 32'h0, 1'b1);
        @(negedge clk);
        check("t6_idle", 32'(req_ready), 32'd1);
        check("t6_notbusy", 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("t6_rescan", 32'(busy), 32'd1);
        check("t6_idx0", 32'(r_index), 32'd0);
        repeat (TLBNUM) @(negedge clk);
        check("t6_done2", 32'(done), 32'd1);
        @(negedge clk);

        // Randomized entries and ops.
        for (int it = 0; it < 12; it++) begin
            va = $urandom;
            for (int i = 0; i < TLBNUM; i++) begin
                int unsigned ps, vppn;
                ps = ($urandom_range(0, 1) == 1) ? 21 : 12;
                vppn = ($urandom_range(0, 2) != 0) ? ((va >> 13) ^ ($urandom & 32'h1FF)) : ($urandom & 32'h7FFFF);
                set_entry(i, ($urandom_range(0, 3) != 0), 1'($urandom), ps,
                          ($urandom_range(0, 1) == 1) ? 10'h12 : 10'($urandom), vppn);
            end
            load_tlb();
            rop = $urandom_range(0, 8);
            if (rop == 8) rop = $urandom_range(7, 31);
            run_inv(5'(rop), 10'h12, va, 1'b0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
